// File: rtl/turbo_pkg.sv
// Shared widths, the register-0 index and the write-back request type
// for the register-file write-back path.
package turbo_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: two request ports, the register-file
// write port, the read-port hazard check and the idle flag.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = turbo_pkg::DATA_W,
  parameter int ADDR_W = turbo_pkg::ADDR_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_hit1;
  logic              chk_hit2;

  logic              idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output chk_addr1, chk_addr2,
    input  req0_ready, req1_ready,
    input  rf_write, rf_waddr, rf_wdata,
    input  chk_hit1, chk_hit2, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  chk_addr1, chk_addr2,
    output req0_ready, req1_ready,
    output rf_write, rf_waddr, rf_wdata,
    output chk_hit1, chk_hit2, idle
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry circular buffer for one write-back source; exposes per-entry
// valid/address so the owner can check read-port hazards against it.
module wb_fifo2
  import turbo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_req_t                push_req,
  output logic                   full,
  output logic                   empty,
  output wb_req_t                head,
  output logic [1:0]             ent_valid,
  output logic [1:0][ADDR_W-1:0] ent_addr
);

  wb_req_t    mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity comes from count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ent_valid[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == i[0]));
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two 2-deep source FIFOs drained one entry per cycle into
// a registered register-file write port. Build macro REGWB_RR_EN selects
// round-robin arbitration; otherwise source 0 has fixed priority.
module regfile_wb_arbiter #(
  parameter int DATA_W = turbo_pkg::DATA_W,
  parameter int ADDR_W = turbo_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  turbo_pkg::wb_req_t   push_req0;
  turbo_pkg::wb_req_t   push_req1;
  turbo_pkg::wb_req_t   head0;
  turbo_pkg::wb_req_t   head1;
  logic                 full0;
  logic                 full1;
  logic                 empty0;
  logic                 empty1;
  logic                 push0;
  logic                 push1;
  logic                 gnt0;
  logic                 gnt1;
  logic [1:0]           ent_valid0;
  logic [1:0]           ent_valid1;
  logic [1:0][ADDR_W-1:0] ent_addr0;
  logic [1:0][ADDR_W-1:0] ent_addr1;

  logic                 rf_write_q;
  logic [ADDR_W-1:0]    rf_waddr_q;
  logic [DATA_W-1:0]    rf_wdata_q;
  logic                 hit1;
  logic                 hit2;

  // Ready is taken from the registered count only, so a full FIFO refuses
  // a push even in the cycle it pops. Writes to register 0 are accepted but dropped.
  assign bus.req0_ready = ~full0;
  assign bus.req1_ready = ~full1;
  assign push0 = bus.req0_valid && ~full0 && (bus.req0_addr != turbo_pkg::REG_ZERO);
  assign push1 = bus.req1_valid && ~full1 && (bus.req1_addr != turbo_pkg::REG_ZERO);

  assign push_req0 = '{addr: bus.req0_addr, data: bus.req0_data};
  assign push_req1 = '{addr: bus.req1_addr, data: bus.req1_data};

  wb_fifo2 u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .pop       (gnt0),
    .push_req  (push_req0),
    .full      (full0),
    .empty     (empty0),
    .head      (head0),
    .ent_valid (ent_valid0),
    .ent_addr  (ent_addr0)
  );

  wb_fifo2 u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .pop       (gnt1),
    .push_req  (push_req1),
    .full      (full1),
    .empty     (empty1),
    .head      (head1),
    .ent_valid (ent_valid1),
    .ent_addr  (ent_addr1)
  );

`ifdef REGWB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!empty0 && !empty1) begin
      if (last_grant) gnt0 = 1'b1;
      else            gnt1 = 1'b1;
    end else if (!empty0) begin
      gnt0 = 1'b1;
    end else if (!empty1) begin
      gnt1 = 1'b1;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!empty0) begin
      gnt0 = 1'b1;
    end else if (!empty1) begin
      gnt1 = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_write_q <= gnt0 | gnt1;
      if (gnt0) begin
        rf_waddr_q <= head0.addr;
        rf_wdata_q <= head0.data;
      end else if (gnt1) begin
        rf_waddr_q <= head1.addr;
        rf_wdata_q <= head1.data;
      end
    end
  end

  assign bus.rf_write = rf_write_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.idle     = empty0 && empty1 && !rf_write_q;

  // A write stays "in flight" from FIFO entry until its rf_write cycle ends.
  always_comb begin
    hit1 = rf_write_q && (rf_waddr_q == bus.chk_addr1);
    hit2 = rf_write_q && (rf_waddr_q == bus.chk_addr2);
    for (int i = 0; i < 2; i++) begin
      hit1 = hit1 || (ent_valid0[i] && (ent_addr0[i] == bus.chk_addr1))
                  || (ent_valid1[i] && (ent_addr1[i] == bus.chk_addr1));
      hit2 = hit2 || (ent_valid0[i] && (ent_addr0[i] == bus.chk_addr2))
                  || (ent_valid1[i] && (ent_addr1[i] == bus.chk_addr2));
    end
    if (bus.chk_addr1 == turbo_pkg::REG_ZERO) hit1 = 1'b0;
    if (bus.chk_addr2 == turbo_pkg::REG_ZERO) hit2 = 1'b0;
  end

  assign bus.chk_hit1 = hit1;
  assign bus.chk_hit2 = hit2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow REGWB_RR_EN when defined.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0]  got_a [8];
    logic [31:0] got_d [8];
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic [31:0] last_d;
    logic [4:0]  last_a;
    int          i0, i1, ng, src, k;
    int          pop_cyc, acc_cyc;
    logic        acc0, acc1, saw_r1_low, pop_ready, r1, any_write;

    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.chk_addr1 = '0; bus.chk_addr2 = '0;

    // reset state before any edge
    #1;
    chk("rst_rf_write", 64'(bus.rf_write), 64'd0);
    chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_idle",     64'(bus.idle), 64'd1);
    chk("rst_ready0",   64'(bus.req0_ready), 64'd1);
    chk("rst_ready1",   64'(bus.req1_ready), 64'd1);
    tick();
    rst = 1'b0;

    // single write from source 0
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'hDEADBEEF;
    bus.chk_addr1 = 5'd7;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("single_queued_write", 64'(bus.rf_write), 64'd0);
    chk("single_queued_idle", 64'(bus.idle), 64'd0);
    chk("single_queued_hit", 64'(bus.chk_hit1), 64'd1);
    tick();
    chk("single_write", 64'(bus.rf_write), 64'd1);
    chk("single_waddr", 64'(bus.rf_waddr), 64'd7);
    chk("single_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
    tick();
    chk("single_done_write", 64'(bus.rf_write), 64'd0);
    chk("single_done_idle", 64'(bus.idle), 64'd1);
    chk("single_hold_waddr", 64'(bus.rf_waddr), 64'd7);
    chk("single_done_hit", 64'(bus.chk_hit1), 64'd0);

    // hazard on a pending source-0 write to r12
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd12; bus.req0_data = 32'h0000_00CC;
    bus.chk_addr1 = 5'd12; bus.chk_addr2 = 5'd0;
    #1;
    chk("haz_before_accept", 64'(bus.chk_hit1), 64'd0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    chk("haz_fifo_hit1", 64'(bus.chk_hit1), 64'd1);
    chk("haz_zero_hit2", 64'(bus.chk_hit2), 64'd0);
    tick();
    chk("haz_wr_write", 64'(bus.rf_write), 64'd1);
    chk("haz_wr_hit1", 64'(bus.chk_hit1), 64'd1);
    chk("haz_wr_hit2", 64'(bus.chk_hit2), 64'd0);
    bus.chk_addr2 = 5'd12;
    #1;
    chk("haz_wr_hit2_match", 64'(bus.chk_hit2), 64'd1);
    tick();
    chk("haz_after_hit1", 64'(bus.chk_hit1), 64'd0);
    chk("haz_after_hit2", 64'(bus.chk_hit2), 64'd0);
    bus.chk_addr1 = 5'd0; bus.chk_addr2 = 5'd0;

    // register 0 discard on source 1
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h0000_1234;
    any_write = 1'b0;
    tick();
    chk("r0_ready1", 64'(bus.req1_ready), 64'd1);
    chk("r0_idle", 64'(bus.idle), 64'd1);
    bus.req1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.rf_write) any_write = 1'b1;
    end
    chk("r0_no_write", 64'(any_write), 64'd0);
    chk("r0_idle_after", 64'(bus.idle), 64'd1);

    // single write from source 1 (leaves last grant on source 1)
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h0000_0055;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk("src1_write", 64'(bus.rf_write), 64'd1);
    chk("src1_waddr", 64'(bus.rf_waddr), 64'd9);
    chk("src1_wdata", 64'(bus.rf_wdata), 64'h55);
    tick();

    // contention: 4 writes per source, back to back
    i0 = 0; i1 = 0; ng = 0; saw_r1_low = 1'b0;
    for (int c = 0; c < 14; c++) begin
      bus.req0_valid = (i0 < 4);
      bus.req0_addr  = 5'(1 + i0);
      bus.req0_data  = 32'hA000_0000 + 32'(i0);
      bus.req1_valid = (i1 < 4);
      bus.req1_addr  = 5'(17 + i1);
      bus.req1_data  = 32'hB000_0000 + 32'(i1);
      #1;
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      if (bus.req1_valid && !bus.req1_ready) saw_r1_low = 1'b1;
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
      if (bus.rf_write) begin
        if (ng < 8) begin
          got_a[ng] = bus.rf_waddr;
          got_d[ng] = bus.rf_wdata;
        end
        ng++;
      end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("cont_grants", 64'(ng), 64'd8);
    chk("cont_ready1_dropped", 64'(saw_r1_low), 64'd1);
    chk("cont_idle", 64'(bus.idle), 64'd1);
    for (int j = 0; j < 8; j++) begin
`ifdef REGWB_RR_EN
      src = j % 2; k = j / 2;
`else
      src = (j < 4) ? 0 : 1; k = j % 4;
`endif
      exp_a = (src == 0) ? 5'(1 + k) : 5'(17 + k);
      exp_d = (src == 0) ? 32'hA000_0000 + 32'(k) : 32'hB000_0000 + 32'(k);
      if (j < ng) begin
        chk($sformatf("cont_addr%0d", j), 64'(got_a[j]), 64'(exp_a));
        chk($sformatf("cont_data%0d", j), 64'(got_d[j]), 64'(exp_d));
      end
    end

    // full FIFO on source 1: no accept in the pop cycle, accept on the next
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3;  bus.req0_data = 32'h30;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd21; bus.req1_data = 32'h210;
    tick();
    bus.req0_addr = 5'd4;  bus.req0_data = 32'h40;
    bus.req1_addr = 5'd22; bus.req1_data = 32'h220;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_addr = 5'd23; bus.req1_data = 32'h230;
    #1;
    chk("full_ready1", 64'(bus.req1_ready), 64'd0);
    chk("full_ready0", 64'(bus.req0_ready), 64'd1);
    pop_cyc = -1; acc_cyc = -1; pop_ready = 1'bx;
    for (int c = 0; c < 10; c++) begin
      r1 = bus.req1_ready;
      tick();
      if (r1 && acc_cyc < 0) begin
        acc_cyc = c;
        bus.req1_valid = 1'b0;
      end
      if (bus.rf_write && bus.rf_waddr == 5'd21) begin
        pop_cyc = c;
        pop_ready = r1;
      end
      if (acc_cyc >= 0) break;
    end
    bus.req1_valid = 1'b0;
    chk("full_pop_no_accept", 64'(pop_ready), 64'd0);
    chk("full_accept_next", 64'(acc_cyc), 64'(pop_cyc + 1));
    last_a = '0; last_d = '0;
    for (int c = 0; c < 10; c++) begin
      if (bus.idle) break;
      tick();
      if (bus.rf_write) begin
        last_a = bus.rf_waddr;
        last_d = bus.rf_wdata;
      end
    end
    chk("full_drain_idle", 64'(bus.idle), 64'd1);
    chk("full_last_addr", 64'(last_a), 64'd23);
    chk("full_last_data", 64'(last_d), 64'h230);

    // reset mid-stream with 3 writes pending
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5;  bus.req0_data = 32'h50;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd25; bus.req1_data = 32'h250;
    tick();
    bus.req0_addr = 5'd6;  bus.req0_data = 32'h60;
    bus.req1_addr = 5'd26; bus.req1_data = 32'h260;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("mid_rf_write", 64'(bus.rf_write), 64'd1);
    chk("mid_ready1", 64'(bus.req1_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rf_write", 64'(bus.rf_write), 64'd0);
    chk("mid_rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("mid_rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("mid_rst_idle",     64'(bus.idle), 64'd1);
    chk("mid_rst_ready0",   64'(bus.req0_ready), 64'd1);
    chk("mid_rst_ready1",   64'(bus.req1_ready), 64'd1);
    tick();
    tick();
    rst = 1'b0;
    any_write = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.rf_write) any_write = 1'b1;
    end
    chk("post_rst_no_write", 64'(any_write), 64'd0);
    chk("post_rst_idle", 64'(bus.idle), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file, which has a single synchronous write port. Two write-back sources (req0: ALU, req1: load unit) each push into a 2-deep FIFO through a valid/ready handshake. The arbiter drains one entry per cycle into registered write-port outputs (`rf_write`, `rf_waddr`, `rf_wdata`). It also reports whether any register named by the read ports still has a write in flight.

## Interface
- `DATA_W`, 32, write-data width
- `ADDR_W`, 5, register index width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  source 0 offers a write
- `req0_ready`  out  1  source 0 FIFO can accept
- `req0_addr`  in  ADDR_W  destination register
- `req0_data`  in  DATA_W  write data
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as source 0, for source 1
- `rf_write`  out  1  write enable to the register file
- `rf_waddr`  out  ADDR_W  write index
- `rf_wdata`  out  DATA_W  write data
- `chk_addr1`, `chk_addr2`  in  ADDR_W  read-port indices to check
- `chk_hit1`, `chk_hit2`  out  1  a pending write targets that index
- `idle`  out  1  both FIFOs empty and `rf_write` low

## Operation
- **Accept:** a push happens at an edge where `reqN_valid` and `reqN_ready` are both high.
- **Ready:** `reqN_ready` = FIFO count < 2.
  - It depends only on the registered count. A full FIFO does not accept even in a cycle where it pops.
- **Register 0:** an accepted write with addr = 0 is consumed and dropped. It never enters the FIFO.
- **FIFO:** each source has a 2-entry circular buffer with a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
  - Push and pop in the same cycle leaves the count unchanged.
  - Order within a source is preserved.
- **Arbitration:** evaluated every cycle over the FIFOs that are not empty.
  - If exactly one is non-empty, it is granted.
  - If both are non-empty, the winner depends on the configuration (see Configuration).
  - The granted head pops at the edge.
- **Output register:** updated every edge.
  - `rf_write` = grant occurred.
  - `rf_waddr` and `rf_wdata` load the popped head when a grant occurs, otherwise they hold.
- **Hazard check:** combinational.
  - `chk_hitK` = 1 if `chk_addrK` is non-zero and matches any valid FIFO entry, or matches `rf_waddr` while `rf_write` = 1.
  - `chk_addrK` = 0 always gives 0.
- **Reset:** all FIFOs empty. `rf_write` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `last_grant` = 1, `idle` = 1, both `ready` outputs = 1.
  - Writes accepted before reset and not yet written are lost. The reset is asynchronous, so any point mid-operation is allowed.
- **No overflow or underflow:** a push into a full FIFO and a pop from an empty FIFO cannot occur by construction.

## Timing
- Accept at edge N → earliest grant at edge N+1 → `rf_write` high from edge N+1 to edge N+2 → register-file update at edge N+2.
- Minimum latency is 2 edges from accept to update. There is no combinational path from `req*` inputs to `rf_*` outputs.
- Throughput is one register-file write per cycle, shared by both sources. Each source sustains one accept per cycle only while it is being granted every cycle.
- Two writes to the same index from the same source reach the register file in acceptance order.
- Writes from different sources reach it in grant order; there is no cross-source ordering guarantee.

## Configuration
- **`REGWB_RR_EN` defined:** round-robin.
  - When both FIFOs are non-empty, grant the source that is not `last_grant`.
  - `last_grant` updates on every grant.
  - No source waits more than 1 grant while the other contends.
- **`REGWB_RR_EN` undefined:** fixed priority, source 0 always wins.
  - `last_grant` is not implemented.
  - Source 1 can starve while source 0 streams.

## Structure
- **Shared package `turbo_pkg`:** `DATA_W`/`ADDR_W` defaults, the `REG_ZERO` index constant, and a `wb_req_t` struct {addr, data}.
- **Sub-module `wb_fifo2`:** 2-entry FIFO (push, pop, full, empty, head, and per-entry valid/addr for the hazard compare). Instantiated twice.
- The arbiter, output register and hazard compare live in the top module.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 writes pending → outputs and ready as listed under Reset; no `rf_write` after release.
- **Single write:** push req0 addr = 7, data = 0xDEADBEEF at edge 0 → `rf_write` = 1 with addr 7 / 0xDEADBEEF during edge 1–2, then `idle`.
- **Register 0 discard:** push req1 addr = 0, data = 0x1234 → ready stays 1, `rf_write` never asserts, `idle` stays 1.
- **Contention (round-robin build):** both sources push 4 writes each back-to-back → grants alternate 0,1,0,1…; ready drops after 2 queued; per-source order kept. Fixed-priority build: all of source 0 first.
- **Hazard:** pending req0 addr = 12 → `chk_hit1` = 1 for `chk_addr1` = 12 until the edge after its `rf_write` cycle ends; `chk_addr2` = 0 → `chk_hit2` = 0.
- **Full FIFO:** fill source 1 to full, then pop and offer in the same cycle → no accept that cycle, accept on the next.
